// File: rtl/math_seed_tbl_mc.sv
// Multi-channel pipelined seed lookup table for the reciprocal / rsqrt iterator.
// Optional even-parity protection of stored entries: define MATH_SEED_PARITY_EN.
module math_seed_tbl_mc #(
  parameter  int unsigned WIDTH    = 68,
  parameter  int unsigned IDX_BITS = 6,
  parameter  int unsigned NCH      = 2,
  localparam int unsigned ADDR_W   = IDX_BITS + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rdy,
  input  logic [NCH-1:0]        rd_vld,
  input  logic [NCH*WIDTH-1:0]  rd_a,
  input  logic [NCH*2-1:0]      rd_mode,
  output logic [NCH*WIDTH-1:0]  res,
  output logic [NCH-1:0]        res_vld,
  output logic [NCH-1:0]        res_oor,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [NCH-1:0]        par_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef MATH_SEED_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [MW-1:0]       mem_word;
  logic [MW-1:0]       mem_q [DEPTH];

  logic [NCH-1:0]        s0_vld_q;
  logic [NCH*ADDR_W-1:0] s0_addr_q, s0_addr_d;
  logic [NCH-1:0]        s0_oor_q, s0_oor_d;

  logic [NCH*WIDTH-1:0]  res_q, res_d;
  logic [NCH-1:0]        res_vld_q, res_oor_q;

  logic                  unused_rd_a;
  assign unused_rd_a = ^rd_a;

  assign rdy = (state_q == S_READY);

  // The clear sweep owns the single write port until the table is ready.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_READY;
      end
      default: mem_we = wr_en;
    endcase
  end

`ifdef MATH_SEED_PARITY_EN
  assign mem_word = {^mem_wdata, mem_wdata};
`else
  assign mem_word = mem_wdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_word;
  end

  // Small-exponent banks take the top k mantissa bits, right-aligned in idx.
  always_comb begin
    logic [11:0]         e;
    logic [11:0]         k;
    logic [IDX_BITS-1:0] mt;
    logic [IDX_BITS-1:0] idx;
    logic [1:0]          md;
    s0_addr_d = '0;
    s0_oor_d  = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      e   = rd_a[ch*WIDTH+54 +: 12];
      mt  = rd_a[ch*WIDTH+54-IDX_BITS +: IDX_BITS];
      md  = rd_mode[ch*2 +: 2];
      k   = e - 12'd2044;
      idx = '0;
      case (md)
        2'd0: idx = mt;
        2'd1: idx = (mt >> 1) | (IDX_BITS'(e[0]) << (IDX_BITS - 1));
        default: begin
          if (k >= 12'd1 && k <= 12'(IDX_BITS)) idx = mt >> (12'(IDX_BITS) - k);
          else s0_oor_d[ch] = 1'b1;
        end
      endcase
      s0_addr_d[ch*ADDR_W +: ADDR_W] = {md, idx};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_vld_q  <= '0;
      s0_addr_q <= '0;
      s0_oor_q  <= '0;
    end else begin
      s0_vld_q  <= rd_vld & {NCH{rdy}};
      s0_addr_q <= s0_addr_d;
      s0_oor_q  <= s0_oor_d;
    end
  end

`ifdef MATH_SEED_PARITY_EN
  logic [NCH-1:0] perr_d, perr_q;
`endif

  // S1: RAM read with same-cycle write forwarding per channel.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [MW-1:0]     word;
    logic              fwd;
    res_d = '0;
`ifdef MATH_SEED_PARITY_EN
    perr_d = '0;
`endif
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      a    = s0_addr_q[ch*ADDR_W +: ADDR_W];
      word = mem_q[a];
      fwd  = mem_we && (mem_waddr == a);
`ifdef MATH_SEED_PARITY_EN
      perr_d[ch] = !fwd && (^word);
`endif
      if (fwd) word = mem_word;
      res_d[ch*WIDTH +: WIDTH] = word[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q     <= '0;
      res_vld_q <= '0;
      res_oor_q <= '0;
`ifdef MATH_SEED_PARITY_EN
      perr_q    <= '0;
`endif
    end else begin
      res_vld_q <= s0_vld_q & {NCH{rdy}};
      res_oor_q <= s0_vld_q & s0_oor_q;
`ifdef MATH_SEED_PARITY_EN
      perr_q    <= s0_vld_q & perr_d;
`endif
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        if (s0_vld_q[ch]) res_q[ch*WIDTH +: WIDTH] <= res_d[ch*WIDTH +: WIDTH];
      end
    end
  end

  assign res     = res_q;
  assign res_vld = res_vld_q;
  assign res_oor = res_oor_q;
`ifdef MATH_SEED_PARITY_EN
  assign par_err = perr_q;
`else
  assign par_err = '0;
`endif

endmodule
